// File: rtl/axil_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axil_arb_pkg
// Description : Shared types and constants for the AXI-Lite round-robin
//               arbiter: channel FSM state encoding, AXI response codes,
//               maximum supported master count and grant index width.
// Revision    : 1.0 - initial release
// ============================================================================
package axil_arb_pkg;

    localparam int MAX_MASTERS = 8;
    // Grant index is sized for the largest configuration so every instance
    // shares one index type regardless of NUM_MASTERS.
    localparam int GRANT_W     = $clog2(MAX_MASTERS);

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/axil_rr_select.sv
`default_nettype none
// ============================================================================
// Module      : axil_rr_select
// Description : Combinational next-grant selector. Returns the first
//               requester after last_i (wrapping NUM_MASTERS-1 -> 0) and a
//               flag telling whether any request is present.
//               With AXIL_ARB_FIXED_PRIO_EN defined the pointer input is
//               removed and the lowest-index requester always wins.
// Ports       : req_i   - request vector, one bit per master
//               last_i  - index of the previously served master (RR only)
//               grant_o - selected master index
//               valid_o - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module axil_rr_select
    import axil_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4
) (
    input  logic [NUM_MASTERS-1:0] req_i,
`ifndef AXIL_ARB_FIXED_PRIO_EN
    input  logic [GRANT_W-1:0]     last_i,
`endif
    output logic [GRANT_W-1:0]     grant_o,
    output logic                   valid_o
);

`ifdef AXIL_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_o = '0;
        valid_o = |req_i;
        // Scan downwards so the lowest requesting index is written last.
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (req_i[i]) grant_o = GRANT_W'(i);
        end
    end
`else
    int idx;

    always_comb begin
        grant_o = '0;
        valid_o = |req_i;
        idx     = 0;
        // Visit candidates from farthest (last+N) to nearest (last+1) so the
        // nearest requester after the pointer overrides the rest.
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            idx = int'(last_i) + k;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if ((i == idx) && req_i[i]) grant_o = GRANT_W'(i);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/axil_lite_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axil_lite_arbiter
// Description : Shares one downstream AXI-Lite port among NUM_MASTERS
//               upstream masters. Write and read channels are arbitrated
//               independently; each channel stays locked to its master from
//               address phase until the response handshake.
//               Build option AXIL_ARB_FIXED_PRIO_EN selects fixed priority
//               (lowest index wins) with no rotating grant pointer.
// Ports       : aclk/aresetn        - clock, synchronous active-low reset
//               m_aw*/m_w*/m_b*     - upstream write channels, slice i = master i
//               m_ar*/m_r*          - upstream read channels, slice i = master i
//               m_axil_*            - shared downstream AXI-Lite port
// Revision    : 1.0 - initial release
// ============================================================================
module axil_lite_arbiter
    import axil_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    // upstream masters
    input  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0] m_awaddr,
    input  logic [NUM_MASTERS-1:0]                m_awvalid,
    output logic [NUM_MASTERS-1:0]                m_awready,
    input  logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0] m_wdata,
    input  logic [NUM_MASTERS-1:0]                m_wvalid,
    output logic [NUM_MASTERS-1:0]                m_wready,
    output logic [NUM_MASTERS*2-1:0]              m_bresp,
    output logic [NUM_MASTERS-1:0]                m_bvalid,
    input  logic [NUM_MASTERS-1:0]                m_bready,
    input  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0] m_araddr,
    input  logic [NUM_MASTERS-1:0]                m_arvalid,
    output logic [NUM_MASTERS-1:0]                m_arready,
    output logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0] m_rdata,
    output logic [NUM_MASTERS*2-1:0]              m_rresp,
    output logic [NUM_MASTERS-1:0]                m_rvalid,
    input  logic [NUM_MASTERS-1:0]                m_rready,
    // shared downstream port
    output logic [AXI_ADDR_WIDTH-1:0]             m_axil_awaddr,
    output logic                                  m_axil_awvalid,
    input  logic                                  m_axil_awready,
    output logic [AXI_DATA_WIDTH-1:0]             m_axil_wdata,
    output logic                                  m_axil_wvalid,
    input  logic                                  m_axil_wready,
    input  logic [1:0]                            m_axil_bresp,
    input  logic                                  m_axil_bvalid,
    output logic                                  m_axil_bready,
    output logic [AXI_ADDR_WIDTH-1:0]             m_axil_araddr,
    output logic                                  m_axil_arvalid,
    input  logic                                  m_axil_arready,
    input  logic [AXI_DATA_WIDTH-1:0]             m_axil_rdata,
    input  logic [1:0]                            m_axil_rresp,
    input  logic                                  m_axil_rvalid,
    output logic                                  m_axil_rready
);

    arb_state_t         wr_state_q, wr_state_d;
    arb_state_t         rd_state_q, rd_state_d;
    logic [GRANT_W-1:0] wr_grant_q, wr_grant_d;
    logic [GRANT_W-1:0] rd_grant_q, rd_grant_d;
    logic               aw_done_q, aw_done_d;
    logic               w_done_q,  w_done_d;

    logic [GRANT_W-1:0] wr_next, rd_next;
    logic               wr_any,  rd_any;

    // Inputs of the currently granted master on each channel
    logic [AXI_ADDR_WIDTH-1:0] sel_awaddr, sel_araddr;
    logic [AXI_DATA_WIDTH-1:0] sel_wdata;
    logic                      sel_awvalid, sel_wvalid, sel_bready;
    logic                      sel_arvalid, sel_rready;

`ifndef AXIL_ARB_FIXED_PRIO_EN
    logic [GRANT_W-1:0] wr_last_q, wr_last_d;
    logic [GRANT_W-1:0] rd_last_q, rd_last_d;
`endif

    axil_rr_select #(.NUM_MASTERS(NUM_MASTERS)) u_wr_sel (
        .req_i   (m_awvalid & m_wvalid),
`ifndef AXIL_ARB_FIXED_PRIO_EN
        .last_i  (wr_last_q),
`endif
        .grant_o (wr_next),
        .valid_o (wr_any)
    );

    axil_rr_select #(.NUM_MASTERS(NUM_MASTERS)) u_rd_sel (
        .req_i   (m_arvalid),
`ifndef AXIL_ARB_FIXED_PRIO_EN
        .last_i  (rd_last_q),
`endif
        .grant_o (rd_next),
        .valid_o (rd_any)
    );

    always_comb begin
        sel_awaddr  = '0;
        sel_awvalid = 1'b0;
        sel_wdata   = '0;
        sel_wvalid  = 1'b0;
        sel_bready  = 1'b0;
        sel_araddr  = '0;
        sel_arvalid = 1'b0;
        sel_rready  = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (GRANT_W'(i) == wr_grant_q) begin
                sel_awaddr  = m_awaddr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                sel_awvalid = m_awvalid[i];
                sel_wdata   = m_wdata[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                sel_wvalid  = m_wvalid[i];
                sel_bready  = m_bready[i];
            end
            if (GRANT_W'(i) == rd_grant_q) begin
                sel_araddr  = m_araddr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                sel_arvalid = m_arvalid[i];
                sel_rready  = m_rready[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    always_comb begin
        wr_state_d     = wr_state_q;
        wr_grant_d     = wr_grant_q;
        aw_done_d      = aw_done_q;
        w_done_d       = w_done_q;
`ifndef AXIL_ARB_FIXED_PRIO_EN
        wr_last_d      = wr_last_q;
`endif
        m_axil_awaddr  = '0;
        m_axil_awvalid = 1'b0;
        m_axil_wdata   = '0;
        m_axil_wvalid  = 1'b0;
        m_axil_bready  = 1'b0;
        m_awready      = '0;
        m_wready       = '0;
        m_bvalid       = '0;
        m_bresp        = {NUM_MASTERS{AXIL_RESP_OKAY}};
        case (wr_state_q)
            IDLE: begin
                if (wr_any) begin
                    wr_grant_d = wr_next;
                    wr_state_d = ADDR;
                end
            end
            ADDR: begin
                // A channel whose handshake already happened stops driving
                // valid so the slave never sees a second beat.
                m_axil_awaddr  = sel_awaddr;
                m_axil_awvalid = sel_awvalid & ~aw_done_q;
                m_axil_wdata   = sel_wdata;
                m_axil_wvalid  = sel_wvalid & ~w_done_q;
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    if (GRANT_W'(i) == wr_grant_q) begin
                        m_awready[i] = m_axil_awready & ~aw_done_q;
                        m_wready[i]  = m_axil_wready  & ~w_done_q;
                    end
                end
                aw_done_d = aw_done_q | (m_axil_awvalid & m_axil_awready);
                w_done_d  = w_done_q  | (m_axil_wvalid  & m_axil_wready);
                if (aw_done_d && w_done_d) begin
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    wr_state_d = RESP;
                end
            end
            RESP: begin
                m_axil_bready = sel_bready;
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    if (GRANT_W'(i) == wr_grant_q) begin
                        m_bvalid[i]      = m_axil_bvalid;
                        m_bresp[i*2 +: 2] = m_axil_bresp;
                    end
                end
                if (m_axil_bvalid && m_axil_bready) begin
`ifndef AXIL_ARB_FIXED_PRIO_EN
                    wr_last_d  = wr_grant_q;
`endif
                    wr_state_d = IDLE;
                end
            end
            default: wr_state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    always_comb begin
        rd_state_d     = rd_state_q;
        rd_grant_d     = rd_grant_q;
`ifndef AXIL_ARB_FIXED_PRIO_EN
        rd_last_d      = rd_last_q;
`endif
        m_axil_araddr  = '0;
        m_axil_arvalid = 1'b0;
        m_axil_rready  = 1'b0;
        m_arready      = '0;
        m_rvalid       = '0;
        m_rdata        = '0;
        m_rresp        = {NUM_MASTERS{AXIL_RESP_OKAY}};
        case (rd_state_q)
            IDLE: begin
                if (rd_any) begin
                    rd_grant_d = rd_next;
                    rd_state_d = ADDR;
                end
            end
            ADDR: begin
                m_axil_araddr  = sel_araddr;
                m_axil_arvalid = sel_arvalid;
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    if (GRANT_W'(i) == rd_grant_q) m_arready[i] = m_axil_arready;
                end
                if (m_axil_arvalid && m_axil_arready) rd_state_d = RESP;
            end
            RESP: begin
                m_axil_rready = sel_rready;
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    if (GRANT_W'(i) == rd_grant_q) begin
                        m_rvalid[i]                                  = m_axil_rvalid;
                        m_rdata[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = m_axil_rdata;
                        m_rresp[i*2 +: 2]                            = m_axil_rresp;
                    end
                end
                if (m_axil_rvalid && m_axil_rready) begin
`ifndef AXIL_ARB_FIXED_PRIO_EN
                    rd_last_d  = rd_grant_q;
`endif
                    rd_state_d = IDLE;
                end
            end
            default: rd_state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_state_q <= IDLE;
            rd_state_q <= IDLE;
            wr_grant_q <= '0;
            rd_grant_q <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
`ifndef AXIL_ARB_FIXED_PRIO_EN
            // Pointer starts at the top index so master 0 wins first.
            wr_last_q  <= GRANT_W'(NUM_MASTERS - 1);
            rd_last_q  <= GRANT_W'(NUM_MASTERS - 1);
`endif
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_grant_q <= wr_grant_d;
            rd_grant_q <= rd_grant_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
`ifndef AXIL_ARB_FIXED_PRIO_EN
            wr_last_q  <= wr_last_d;
            rd_last_q  <= rd_last_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axil_lite_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_lite_arbiter
// Description : Directed self-checking bench for axil_lite_arbiter with four
//               masters; the bench plays the downstream slave by hand.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_lite_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;

    logic            aclk;
    logic            aresetn;
    logic [N*AW-1:0] m_awaddr;
    logic [N-1:0]    m_awvalid, m_awready;
    logic [N*DW-1:0] m_wdata;
    logic [N-1:0]    m_wvalid, m_wready;
    logic [N*2-1:0]  m_bresp;
    logic [N-1:0]    m_bvalid, m_bready;
    logic [N*AW-1:0] m_araddr;
    logic [N-1:0]    m_arvalid, m_arready;
    logic [N*DW-1:0] m_rdata;
    logic [N*2-1:0]  m_rresp;
    logic [N-1:0]    m_rvalid, m_rready;
    logic [AW-1:0]   m_axil_awaddr, m_axil_araddr;
    logic [DW-1:0]   m_axil_wdata, m_axil_rdata;
    logic            m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
    logic [1:0]      m_axil_bresp, m_axil_rresp;
    logic            m_axil_bvalid, m_axil_bready;
    logic            m_axil_arvalid, m_axil_arready, m_axil_rvalid, m_axil_rready;

    int n_checks = 0;
    int n_errors = 0;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    axil_lite_arbiter #(
        .NUM_MASTERS(N), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awvalid(m_axil_awvalid),
        .m_axil_awready(m_axil_awready), .m_axil_wdata(m_axil_wdata),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
        .m_axil_bready(m_axil_bready), .m_axil_araddr(m_axil_araddr),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked
    // one unit later, well clear of the next edge.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clr_inputs();
        m_awaddr = '0; m_awvalid = '0; m_wdata = '0; m_wvalid = '0; m_bready = '0;
        m_araddr = '0; m_arvalid = '0; m_rready = '0;
        m_axil_awready = 1'b0; m_axil_wready = 1'b0;
        m_axil_bresp = 2'b00; m_axil_bvalid = 1'b0;
        m_axil_arready = 1'b0; m_axil_rdata = '0; m_axil_rresp = 2'b00; m_axil_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    initial begin
        clr_inputs();
        aresetn = 1'b0;
        tick();
        tick();
        #1;
        // ---------------- reset state ----------------
        check("rst_dn_valid", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid,
                               m_axil_bready, m_axil_rready}, 128'h0);
        check("rst_up_ready", {m_awready, m_wready, m_arready, m_bvalid, m_rvalid}, 128'h0);
        check("rst_up_resp",  {m_bresp, m_rresp}, 128'h0);
        check("rst_rdata",    m_rdata, 128'h0);
        check("rst_dn_addr",  {m_axil_awaddr, m_axil_wdata, m_axil_araddr}, 128'h0);
        aresetn = 1'b1;

        // ---------------- single write, master 2 ----------------
        m_awaddr[2*AW +: AW] = 32'h4000_0010;
        m_wdata[2*DW +: DW]  = 32'hDEAD_BEEF;
        m_awvalid = 4'b0100;
        m_wvalid  = 4'b0100;
        #1;
        check("w1_latency", m_axil_awvalid, 1'b0);
        tick();
        #1;
        check("w1_awvalid", {m_axil_awvalid, m_axil_wvalid}, 2'b11);
        check("w1_awaddr",  m_axil_awaddr, 32'h4000_0010);
        check("w1_wdata",   m_axil_wdata,  32'hDEAD_BEEF);
        m_axil_awready = 1'b1; m_axil_wready = 1'b1;
        #1;
        check("w1_ready_route", {m_awready, m_wready}, 8'b0100_0100);
        tick();
        m_awvalid = '0; m_wvalid = '0; m_axil_awready = 1'b0; m_axil_wready = 1'b0;
        m_axil_bvalid = 1'b1; m_axil_bresp = 2'b00; m_bready = 4'b0100;
        #1;
        check("w1_bvalid", m_bvalid, 4'b0100);
        check("w1_bresp",  m_bresp, 8'h00);
        check("w1_bready", m_axil_bready, 1'b1);
        tick();
        m_axil_bvalid = 1'b0;
        #1;
        check("w1_idle", {m_bvalid, m_axil_bready, m_axil_awvalid}, 6'b0);

        // ---------------- round robin, all four writing ----------------
        clr_inputs();
        do_reset();
        for (int i = 0; i < N; i++) begin
            m_awaddr[i*AW +: AW] = 32'h100 * (i + 1);
            m_wdata[i*DW +: DW]  = 32'hA0 + i;
        end
        m_awvalid = 4'hF; m_wvalid = 4'hF; m_bready = 4'hF;
        for (int t = 0; t < 5; t++) begin
            int g;
            g = exp_order[t];
            tick();
            m_axil_awready = 1'b1; m_axil_wready = 1'b1;
            #1;
            check("rr_awaddr",  m_axil_awaddr, 128'(32'h100 * (g + 1)));
            check("rr_wdata",   m_axil_wdata,  128'(32'hA0 + g));
            check("rr_awready", m_awready, 128'(1) << g);
            tick();
            m_axil_awready = 1'b0; m_axil_wready = 1'b0;
            m_axil_bvalid = 1'b1; m_axil_bresp = 2'(g);
            #1;
            check("rr_bvalid", m_bvalid, 128'(1) << g);
            check("rr_bresp",  m_bresp, 128'(g) << (2 * g));
            tick();
            m_axil_bvalid = 1'b0;
        end

        // ---------------- concurrent read (m1) and write (m3) ----------------
        clr_inputs();
        m_araddr[1*AW +: AW] = 32'h2000_0004;
        m_arvalid = 4'b0010;
        m_awaddr[3*AW +: AW] = 32'h3000_0008;
        m_wdata[3*DW +: DW]  = 32'h1234_5678;
        m_awvalid = 4'b1000; m_wvalid = 4'b1000;
        tick();
        #1;
        check("cc_valids", {m_axil_arvalid, m_axil_awvalid}, 2'b11);
        check("cc_addrs",  {m_axil_araddr, m_axil_awaddr}, 64'h2000_0004_3000_0008);
        m_axil_arready = 1'b1; m_axil_awready = 1'b1; m_axil_wready = 1'b1;
        #1;
        check("cc_readies", {m_arready, m_awready}, 8'b0010_1000);
        tick();
        m_arvalid = '0; m_awvalid = '0; m_wvalid = '0;
        m_axil_arready = 1'b0; m_axil_awready = 1'b0; m_axil_wready = 1'b0;
        m_axil_rvalid = 1'b1; m_axil_rdata = 32'hCAFE_F00D; m_axil_rresp = 2'b00;
        m_axil_bvalid = 1'b1; m_axil_bresp = 2'b01;
        m_rready = 4'b0010; m_bready = 4'b1000;
        #1;
        check("cc_rvalid", m_rvalid, 4'b0010);
        check("cc_rdata",  m_rdata, 128'(32'hCAFE_F00D) << 32);
        check("cc_bvalid", m_bvalid, 4'b1000);
        check("cc_bresp",  m_bresp, 8'b01_00_00_00);
        tick();
        clr_inputs();

        // ---------------- AW accepted two cycles before W ----------------
        m_awaddr[0 +: AW] = 32'h5000_0000;
        m_wdata[0 +: DW]  = 32'h0BAD_F00D;
        m_awvalid = 4'b0001; m_wvalid = 4'b0001;
        tick();
        m_axil_awready = 1'b1;
        #1;
        check("sp_awready", {m_awready, m_wready}, 8'b0001_0000);
        tick();
        m_awvalid = '0;
        #1;
        check("sp_aw_drop1", {m_axil_awvalid, m_axil_wvalid}, 2'b01);
        check("sp_aw_ready_off", m_awready, 4'b0000);
        tick();
        #1;
        check("sp_aw_drop2", {m_axil_awvalid, m_axil_wvalid, m_axil_bready}, 3'b010);
        m_axil_wready = 1'b1;
        #1;
        check("sp_wready", m_wready, 4'b0001);
        tick();
        m_wvalid = '0; m_axil_awready = 1'b0; m_axil_wready = 1'b0;
        m_axil_bvalid = 1'b1; m_bready = 4'b0001;
        #1;
        check("sp_resp", {m_bvalid, m_axil_wvalid, m_axil_awvalid}, 6'b0001_00);
        tick();
        m_axil_bvalid = 1'b0;
        tick();
        #1;
        check("sp_single", {m_axil_awvalid, m_axil_wvalid}, 2'b00);

        // ---------------- unmapped read, DECERR passthrough ----------------
        clr_inputs();
        m_araddr[2*AW +: AW] = 32'hFFFF_0000;
        m_arvalid = 4'b0100;
        tick();
        m_axil_arready = 1'b1;
        #1;
        check("de_araddr", m_axil_araddr, 32'hFFFF_0000);
        tick();
        m_arvalid = '0; m_axil_arready = 1'b0;
        m_axil_rvalid = 1'b1; m_axil_rresp = 2'b11; m_axil_rdata = '0; m_rready = 4'b0100;
        #1;
        check("de_rresp",  m_rresp, 8'b00_11_00_00);
        check("de_rdata",  m_rdata, 128'h0);
        check("de_rvalid", m_rvalid, 4'b0100);
        tick();
        clr_inputs();

        // ---------------- reset during write RESP ----------------
        m_awvalid = 4'b0010; m_wvalid = 4'b0010;
        tick();
        m_axil_awready = 1'b1; m_axil_wready = 1'b1;
        tick();
        m_awvalid = '0; m_wvalid = '0; m_axil_awready = 1'b0; m_axil_wready = 1'b0;
        m_axil_bvalid = 1'b1; m_bready = 4'hF;
        #1;
        check("rr_mid_bvalid", m_bvalid, 4'b0010);
        aresetn = 1'b0;
        tick();
        #1;
        check("rm_outputs", {m_bvalid, m_axil_bready, m_axil_awvalid, m_axil_wvalid,
                             m_awready, m_wready}, 128'h0);
        m_axil_bvalid = 1'b0;
        aresetn = 1'b1;
        for (int i = 0; i < N; i++) m_awaddr[i*AW +: AW] = 32'h100 * (i + 1);
        m_awvalid = 4'hF; m_wvalid = 4'hF;
        tick();
        #1;
        check("rm_first_grant", m_axil_awaddr, 32'h100);
        clr_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
